// File: rtl/kpn_pkg.sv
// Shared KPN fabric types: token width and token type used by split, FIFO and consumers.
package kpn_pkg;
  localparam int TOKEN_W = 16;
  typedef logic [TOKEN_W-1:0] kpn_token_t;
endpackage

// File: rtl/kpn_fifo_mem.sv
// Register-array storage for the KPN FIFO channel: one synchronous write port,
// one asynchronous read port. Contents are intentionally never reset.
module kpn_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kpn_fifo_channel.sv
// Bounded first-word-fall-through FIFO channel between the split stage and a
// downstream KPN process; writes while full are dropped and flagged sticky.
import kpn_pkg::*;

module kpn_fifo_channel #(
  parameter  int DATA_W = TOKEN_W,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  // Flags come only from registered occupancy, so no input reaches them combinationally.
  assign full     = (count_q == DEPTH_C);
  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;

  assign push = wr_en && !full;
  assign pop  = rd_valid && rd_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  kpn_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .raddr_i(rd_ptr_q),
    .rdata_o(head)
  );

  // Storage is not cleared by reset, so the head is masked to zero while empty.
  assign rd_data = rd_valid ? head : '0;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed self-checking bench for kpn_fifo_channel (DEPTH = 8, 16-bit tokens).
module tb_kpn_fifo_channel;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              full;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W:0]   count;
  logic              overflow;

  int total  = 0;
  int passed = 0;

  kpn_fifo_channel #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .count   (count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);

    // Pop requests while empty have no effect
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_count",    32'(count),    32'd0);
      chk("idle_rd_valid", 32'(rd_valid), 32'd0);
      chk("idle_overflow", 32'(overflow), 32'd0);
    end
    rd_ready = 1'b0;

    // Single token, one-cycle latency
    wr_en   = 1'b1;
    wr_data = 16'hA5A5;
    tick();
    wr_en = 1'b0;
    chk("single_rd_valid", 32'(rd_valid), 32'd1);
    chk("single_rd_data",  32'(rd_data),  32'hA5A5);
    chk("single_count",    32'(count),    32'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("single_pop_valid", 32'(rd_valid), 32'd0);
    chk("single_pop_count", 32'(count),    32'd0);

    // Fill to full; head must stay stable while not popped
    for (int i = 1; i <= 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(i);
      tick();
      chk("fill_head_stable", 32'(rd_data), 32'h0001);
      chk("fill_count",       32'(count),   32'(i));
    end
    chk("fill_full",     32'(full),     32'd1);
    chk("fill_overflow", 32'(overflow), 32'd0);
    wr_data = 16'h0009;
    tick();
    wr_en = 1'b0;
    chk("ovf_overflow", 32'(overflow), 32'd1);
    chk("ovf_count",    32'(count),    32'd8);
    chk("ovf_full",     32'(full),     32'd1);
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_data",  32'(rd_data),  32'(i));
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_empty",    32'(rd_valid), 32'd0);
    chk("drain_count",    32'(count),    32'd0);
    chk("drain_ovf_hold", 32'(overflow), 32'd1);

    // Wrap-around: offset pointers by 6, then fill and drain across the wrap
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 16'h0200 + 16'(i);
      tick();
    end
    wr_en    = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("pre_wrap_data", 32'(rd_data), 32'h0200 + 32'(i));
      tick();
    end
    rd_ready = 1'b0;
    wr_en    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 16'h1000 + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("wrap_full", 32'(full), 32'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("wrap_data", 32'(rd_data), 32'h1000 + 32'(i));
      tick();
    end
    rd_ready = 1'b0;
    chk("wrap_count", 32'(count), 32'd0);

    // Simultaneous push/pop at count 3
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 16'h3000 + 16'(i);
      tick();
    end
    chk("sim_pre_count", 32'(count), 32'd3);
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 16'h3003 + 16'(i);
      chk("sim_data", 32'(rd_data), 32'h3000 + 32'(i));
      tick();
      chk("sim_count", 32'(count), 32'd3);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sim_tail_data", 32'(rd_data), 32'h300A + 32'(i));
      tick();
    end
    rd_ready = 1'b0;
    chk("sim_end_count", 32'(count), 32'd0);

    // Simultaneous push/pop at count 1: new token becomes head
    wr_en   = 1'b1;
    wr_data = 16'h4000;
    tick();
    wr_data  = 16'h4001;
    rd_ready = 1'b1;
    tick();
    wr_en    = 1'b0;
    rd_ready = 1'b0;
    chk("pp1_count", 32'(count),   32'd1);
    chk("pp1_data",  32'(rd_data), 32'h4001);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;

    // Reset mid-operation with a concurrent write
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 16'h5000 + 16'(i);
      tick();
    end
    chk("mid_count",    32'(count),    32'd5);
    chk("mid_overflow", 32'(overflow), 32'd1);
    reset   = 1'b1;
    wr_data = 16'hBEEF;
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    chk("mrst_count",    32'(count),    32'd0);
    chk("mrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mrst_overflow", 32'(overflow), 32'd0);
    chk("mrst_full",     32'(full),     32'd0);
    chk("mrst_rd_data",  32'(rd_data),  32'd0);
    tick();
    chk("mrst_discard", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
